// File: rtl/rf_rename_mp.sv
// rtl/rf_rename_mp.sv - multi-issue register file with ROB rename tags, commit forwarding and jalr port
module rf_rename_mp #(
    parameter int XLEN          = 32,
    parameter int REG_NUM_WIDTH = 5,
    parameter int TAG_WIDTH     = 5,
    parameter int ISSUE_W       = 2,
    parameter int COMMIT_W      = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              need_flush_in,
    input  logic [COMMIT_W-1:0]               cm_valid,
    input  logic [COMMIT_W*REG_NUM_WIDTH-1:0] cm_rd,
    input  logic [COMMIT_W*XLEN-1:0]          cm_value,
    input  logic [COMMIT_W*TAG_WIDTH-1:0]     cm_tag,
    input  logic [ISSUE_W-1:0]                dec_valid,
    input  logic [ISSUE_W*REG_NUM_WIDTH-1:0]  dec_rd,
    input  logic [ISSUE_W*REG_NUM_WIDTH-1:0]  dec_rs1,
    input  logic [ISSUE_W*REG_NUM_WIDTH-1:0]  dec_rs2,
    input  logic [ISSUE_W*TAG_WIDTH-1:0]      dec_new_tag,
    input  logic [REG_NUM_WIDTH-1:0]          if_rs_jalr,
    output logic [ISSUE_W*XLEN-1:0]           value1_out,
    output logic [ISSUE_W*XLEN-1:0]           value2_out,
    output logic [ISSUE_W*TAG_WIDTH-1:0]      dependency1_out,
    output logic [ISSUE_W*TAG_WIDTH-1:0]      dependency2_out,
    output logic [XLEN-1:0]                   value_jalr_out,
    output logic                              jalr_busy_out
);

    localparam int RW      = REG_NUM_WIDTH;
    localparam int TW      = TAG_WIDTH;
    localparam int REG_NUM = 1 << REG_NUM_WIDTH;
    localparam logic [TW-1:0] TAG_NONE = '1;

    logic [XLEN-1:0] regs      [REG_NUM];
    logic [TW-1:0]   tags      [REG_NUM];
    logic [XLEN-1:0] regs_next [REG_NUM];
    logic [TW-1:0]   tags_next [REG_NUM];

    logic [RW-1:0]   src;
    logic [XLEN-1:0] src_val;
    logic [TW-1:0]   src_tag;
    logic            src_hit;

    // Next architectural state: commits first, then either flush wipes all tags or renames land on top.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            regs_next[r] = regs[r];
            tags_next[r] = tags[r];
        end
        // Ascending port order lets the youngest commit to a register win the data write;
        // tag clearing compares against the pre-edge tag so any matching port clears it.
        for (int c = 0; c < COMMIT_W; c++) begin
            if (cm_valid[c] && (cm_rd[c*RW +: RW] != '0)) begin
                regs_next[cm_rd[c*RW +: RW]] = cm_value[c*XLEN +: XLEN];
                if (cm_tag[c*TW +: TW] == tags[cm_rd[c*RW +: RW]]) begin
                    tags_next[cm_rd[c*RW +: RW]] = TAG_NONE;
                end
            end
        end
        if (need_flush_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
                tags_next[r] = TAG_NONE;
            end
        end else begin
            // Youngest slot wins; a rename always overrides a same-cycle tag clear.
            for (int k = 0; k < ISSUE_W; k++) begin
                if (dec_valid[k] && (dec_rd[k*RW +: RW] != '0)) begin
                    tags_next[dec_rd[k*RW +: RW]] = dec_new_tag[k*TW +: TW];
                end
            end
        end
    end

    // State register: async reset clears everything, rdy_in gates all updates.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
                tags[r] <= TAG_NONE;
            end
        end else if (rdy_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= regs_next[r];
                tags[r] <= tags_next[r];
            end
        end
    end

    // Operand lookup per slot and source: x0, then older-slot rename, then commit forward, then file.
    always_comb begin
        value1_out      = '0;
        value2_out      = '0;
        dependency1_out = '0;
        dependency2_out = '0;
        src             = '0;
        src_val         = '0;
        src_tag         = TAG_NONE;
        src_hit         = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int s = 0; s < 2; s++) begin
                src     = (s == 0) ? dec_rs1[k*RW +: RW] : dec_rs2[k*RW +: RW];
                src_val = regs[src];
                src_tag = tags[src];
                src_hit = 1'b0;
                // Ascending scan so the youngest older slot that renames src is the one kept.
                for (int j = 0; j < ISSUE_W; j++) begin
                    if ((j < k) && dec_valid[j] && (dec_rd[j*RW +: RW] == src)) begin
                        src_hit = 1'b1;
                        src_val = '0;
                        src_tag = dec_new_tag[j*TW +: TW];
                    end
                end
                if (!src_hit) begin
                    for (int c = 0; c < COMMIT_W; c++) begin
                        if (cm_valid[c] && (cm_rd[c*RW +: RW] == src)) begin
                            src_val = cm_value[c*XLEN +: XLEN];
                            src_tag = (cm_tag[c*TW +: TW] == tags[src]) ? TAG_NONE : tags[src];
                        end
                    end
                end
                if (src == '0) begin
                    src_val = '0;
                    src_tag = TAG_NONE;
                end
                if (s == 0) begin
                    value1_out[k*XLEN +: XLEN]    = src_val;
                    dependency1_out[k*TW +: TW]   = src_tag;
                end else begin
                    value2_out[k*XLEN +: XLEN]    = src_val;
                    dependency2_out[k*TW +: TW]   = src_tag;
                end
            end
        end
    end

    assign value_jalr_out = (if_rs_jalr == '0) ? '0 : regs[if_rs_jalr];
    assign jalr_busy_out  = (tags[if_rs_jalr] != TAG_NONE);

endmodule

// File: tb/tb_rf_rename_mp.sv
// tb/tb_rf_rename_mp.sv - randomized and directed checks of rf_rename_mp against a behavioural model
module tb_rf_rename_mp;

    localparam int XL = 32;
    localparam int RW = 5;
    localparam int TW = 5;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam logic [TW-1:0] NONE = '1;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              need_flush_in;
    logic [CW-1:0]     cm_valid;
    logic [CW*RW-1:0]  cm_rd;
    logic [CW*XL-1:0]  cm_value;
    logic [CW*TW-1:0]  cm_tag;
    logic [IW-1:0]     dec_valid;
    logic [IW*RW-1:0]  dec_rd;
    logic [IW*RW-1:0]  dec_rs1;
    logic [IW*RW-1:0]  dec_rs2;
    logic [IW*TW-1:0]  dec_new_tag;
    logic [RW-1:0]     if_rs_jalr;
    logic [IW*XL-1:0]  value1_out;
    logic [IW*XL-1:0]  value2_out;
    logic [IW*TW-1:0]  dependency1_out;
    logic [IW*TW-1:0]  dependency2_out;
    logic [XL-1:0]     value_jalr_out;
    logic              jalr_busy_out;

    int vectors = 0;
    int errors  = 0;

    logic [XL-1:0] m_regs [32];
    logic [TW-1:0] m_tags [32];

    rf_rename_mp dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value), .cm_tag(cm_tag),
        .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_new_tag(dec_new_tag), .if_rs_jalr(if_rs_jalr),
        .value1_out(value1_out), .value2_out(value2_out),
        .dependency1_out(dependency1_out), .dependency2_out(dependency2_out),
        .value_jalr_out(value_jalr_out), .jalr_busy_out(jalr_busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic clear_inputs();
        rdy_in = 1'b1; need_flush_in = 1'b0;
        cm_valid = '0; cm_rd = '0; cm_value = '0; cm_tag = '0;
        dec_valid = '0; dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_new_tag = '0;
        if_rs_jalr = '0;
    endtask

    task automatic set_cm(input int p, input logic [RW-1:0] rd, input logic [XL-1:0] v, input logic [TW-1:0] t);
        cm_valid[p] = 1'b1; cm_rd[p*RW +: RW] = rd; cm_value[p*XL +: XL] = v; cm_tag[p*TW +: TW] = t;
    endtask

    task automatic set_dec(input int k, input logic vld, input logic [RW-1:0] rd, input logic [TW-1:0] t);
        dec_valid[k] = vld; dec_rd[k*RW +: RW] = rd; dec_new_tag[k*TW +: TW] = t;
    endtask

    // Inputs are driven just after the falling edge; one call advances exactly one rising edge.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Operand as the rules describe it, evaluated in priority order.
    function automatic void model_read(input int k, input logic [RW-1:0] rs,
                                       output logic [XL-1:0] v, output logic [TW-1:0] t);
        v = m_regs[rs];
        t = m_tags[rs];
        if (rs == 0) begin v = '0; t = NONE; return; end
        for (int j = k - 1; j >= 0; j--) begin
            if (dec_valid[j] && dec_rd[j*RW +: RW] == rs) begin
                v = '0; t = dec_new_tag[j*TW +: TW]; return;
            end
        end
        for (int c = CW - 1; c >= 0; c--) begin
            if (cm_valid[c] && cm_rd[c*RW +: RW] == rs) begin
                v = cm_value[c*XL +: XL];
                t = (cm_tag[c*TW +: TW] == m_tags[rs]) ? NONE : m_tags[rs];
                return;
            end
        end
    endfunction

    function automatic void model_update();
        logic [XL-1:0] nv [32];
        logic [TW-1:0] nt [32];
        for (int r = 0; r < 32; r++) begin
            logic clr;
            int   last;
            nv[r] = m_regs[r];
            clr = 1'b0;
            last = -1;
            for (int c = 0; c < CW; c++) begin
                if (cm_valid[c] && cm_rd[c*RW +: RW] == r[RW-1:0] && r != 0) begin
                    last = c;
                    if (cm_tag[c*TW +: TW] == m_tags[r]) clr = 1'b1;
                end
            end
            if (last >= 0) nv[r] = cm_value[last*XL +: XL];
            nt[r] = clr ? NONE : m_tags[r];
            if (need_flush_in) nt[r] = NONE;
            else if (r != 0) begin
                for (int k = IW - 1; k >= 0; k--) begin
                    if (dec_valid[k] && dec_rd[k*RW +: RW] == r[RW-1:0]) begin
                        nt[r] = dec_new_tag[k*TW +: TW];
                        break;
                    end
                end
            end
        end
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = nv[r];
            m_tags[r] = nt[r];
        end
    endfunction

    task automatic test_reset();
        clear_inputs();
        set_cm(0, 5'd5, 32'h55, 5'd0);
        set_dec(0, 1'b1, 5'd5, 5'd3);
        tick();
        clear_inputs();
        dec_rs1[0 +: RW] = 5'd5;
        if_rs_jalr = 5'd5;
        #1;
        vectors++;
        if (value1_out[0 +: XL] !== 32'h55 || dependency1_out[0 +: TW] !== 5'd3) begin
            errors++;
            $display("FAIL reset_setup: got %h/%0d want 00000055/3", value1_out[0 +: XL], dependency1_out[0 +: TW]);
        end
        vectors++;
        if (value_jalr_out !== 32'h55 || jalr_busy_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup_jalr: got %h/%b want 00000055/1", value_jalr_out, jalr_busy_out);
        end
        rst_in = 1'b1;
        #1;
        vectors++;
        if (value1_out[0 +: XL] !== 32'h0 || dependency1_out[0 +: TW] !== NONE) begin
            errors++;
            $display("FAIL reset_async: got %h/%0d want 0/31", value1_out[0 +: XL], dependency1_out[0 +: TW]);
        end
        vectors++;
        if (value_jalr_out !== 32'h0 || jalr_busy_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_jalr: got %h/%b want 0/0", value_jalr_out, jalr_busy_out);
        end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_intra_group();
        clear_inputs();
        set_dec(0, 1'b1, 5'd3, 5'd4);
        dec_rs1[1*RW +: RW] = 5'd3;
        #1;
        vectors++;
        if (dependency1_out[1*TW +: TW] !== 5'd4 || value1_out[1*XL +: XL] !== 32'h0) begin
            errors++;
            $display("FAIL intra_bypass: got %h/%0d want 0/4", value1_out[1*XL +: XL], dependency1_out[1*TW +: TW]);
        end
        tick();
        clear_inputs();
        dec_rs1[0 +: RW] = 5'd3;
        #1;
        vectors++;
        if (dependency1_out[0 +: TW] !== 5'd4) begin
            errors++;
            $display("FAIL intra_stored: got %0d want 4", dependency1_out[0 +: TW]);
        end
    endtask

    task automatic test_commit_forward();
        clear_inputs();
        set_dec(0, 1'b1, 5'd5, 5'd2);
        tick();
        clear_inputs();
        set_cm(0, 5'd5, 32'hDEAD, 5'd2);
        dec_rs1[0 +: RW] = 5'd5;
        #1;
        vectors++;
        if (value1_out[0 +: XL] !== 32'hDEAD || dependency1_out[0 +: TW] !== NONE) begin
            errors++;
            $display("FAIL commit_fwd: got %h/%0d want 0000dead/31", value1_out[0 +: XL], dependency1_out[0 +: TW]);
        end
        tick();
        clear_inputs();
        dec_rs1[0 +: RW] = 5'd5;
        #1;
        vectors++;
        if (value1_out[0 +: XL] !== 32'hDEAD || dependency1_out[0 +: TW] !== NONE) begin
            errors++;
            $display("FAIL commit_stored: got %h/%0d want 0000dead/31", value1_out[0 +: XL], dependency1_out[0 +: TW]);
        end
    endtask

    task automatic test_stale_commit();
        clear_inputs();
        set_dec(0, 1'b1, 5'd5, 5'd7);
        tick();
        clear_inputs();
        set_cm(0, 5'd5, 32'h11, 5'd2);
        dec_rs1[0 +: RW] = 5'd5;
        #1;
        vectors++;
        if (value1_out[0 +: XL] !== 32'h11 || dependency1_out[0 +: TW] !== 5'd7) begin
            errors++;
            $display("FAIL stale_fwd: got %h/%0d want 00000011/7", value1_out[0 +: XL], dependency1_out[0 +: TW]);
        end
        tick();
        clear_inputs();
        dec_rs2[0 +: RW] = 5'd5;
        #1;
        vectors++;
        if (value2_out[0 +: XL] !== 32'h11 || dependency2_out[0 +: TW] !== 5'd7) begin
            errors++;
            $display("FAIL stale_stored: got %h/%0d want 00000011/7", value2_out[0 +: XL], dependency2_out[0 +: TW]);
        end
    endtask

    task automatic test_collisions();
        clear_inputs();
        set_cm(0, 5'd6, 32'h1, 5'd0);
        set_cm(1, 5'd6, 32'h2, 5'd0);
        set_cm(1, 5'd6, 32'h2, 5'd0);
        set_dec(0, 1'b1, 5'd6, 5'd5);
        tick();
        clear_inputs();
        if_rs_jalr = 5'd6;
        #1;
        vectors++;
        if (value_jalr_out !== 32'h2) begin
            errors++;
            $display("FAIL collide_value: got %h want 00000002", value_jalr_out);
        end
        set_cm(0, 5'd6, 32'h3, 5'd5);
        set_dec(1, 1'b1, 5'd6, 5'd9);
        tick();
        clear_inputs();
        dec_rs1[0 +: RW] = 5'd6;
        #1;
        vectors++;
        if (dependency1_out[0 +: TW] !== 5'd9 || value1_out[0 +: XL] !== 32'h3) begin
            errors++;
            $display("FAIL collide_rename: got %h/%0d want 00000003/9", value1_out[0 +: XL], dependency1_out[0 +: TW]);
        end
        set_cm(0, 5'd0, 32'h99, 5'd1);
        set_dec(0, 1'b1, 5'd0, 5'd2);
        tick();
        clear_inputs();
        if_rs_jalr = 5'd0;
        #1;
        vectors++;
        if (value_jalr_out !== 32'h0 || jalr_busy_out !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: got %h/%b want 0/0", value_jalr_out, jalr_busy_out);
        end
    endtask

    task automatic test_flush_stall();
        clear_inputs();
        set_dec(0, 1'b1, 5'd7, 5'd3);
        set_dec(1, 1'b1, 5'd9, 5'd4);
        tick();
        clear_inputs();
        need_flush_in = 1'b1;
        set_cm(0, 5'd7, 32'h70, 5'd1);
        set_dec(0, 1'b1, 5'd8, 5'd6);
        tick();
        clear_inputs();
        dec_rs1[0 +: RW] = 5'd7;
        dec_rs2[0 +: RW] = 5'd8;
        dec_rs1[1*RW +: RW] = 5'd9;
        #1;
        vectors++;
        if (value1_out[0 +: XL] !== 32'h70 || dependency1_out[0 +: TW] !== NONE) begin
            errors++;
            $display("FAIL flush_x7: got %h/%0d want 00000070/31", value1_out[0 +: XL], dependency1_out[0 +: TW]);
        end
        vectors++;
        if (dependency2_out[0 +: TW] !== NONE || dependency1_out[1*TW +: TW] !== NONE) begin
            errors++;
            $display("FAIL flush_tags: got %0d/%0d want 31/31", dependency2_out[0 +: TW], dependency1_out[1*TW +: TW]);
        end
        rdy_in = 1'b0;
        set_cm(0, 5'd7, 32'h5, 5'd1);
        set_dec(0, 1'b1, 5'd9, 5'd2);
        tick();
        clear_inputs();
        dec_rs1[0 +: RW] = 5'd7;
        dec_rs2[0 +: RW] = 5'd9;
        #1;
        vectors++;
        if (value1_out[0 +: XL] !== 32'h70 || dependency2_out[0 +: TW] !== NONE) begin
            errors++;
            $display("FAIL stall_hold: got %h/%0d want 00000070/31", value1_out[0 +: XL], dependency2_out[0 +: TW]);
        end
    endtask

    task automatic test_random();
        logic [XL-1:0] ev;
        logic [TW-1:0] et;
        clear_inputs();
        rst_in = 1'b1;
        #1;
        rst_in = 1'b0;
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_tags[r] = NONE;
        end
        for (int n = 0; n < 500; n++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            need_flush_in = ($urandom_range(0, 19) == 0);
            for (int c = 0; c < CW; c++) begin
                logic [RW-1:0] rd;
                rd = RW'($urandom_range(0, 7));
                cm_valid[c] = $urandom_range(0, 1);
                cm_rd[c*RW +: RW] = rd;
                cm_value[c*XL +: XL] = $urandom;
                cm_tag[c*TW +: TW] = $urandom_range(0, 1) ? m_tags[rd] : TW'($urandom_range(0, 7));
            end
            for (int k = 0; k < IW; k++) begin
                dec_valid[k] = $urandom_range(0, 1);
                dec_rd[k*RW +: RW]  = RW'($urandom_range(0, 7));
                dec_rs1[k*RW +: RW] = RW'($urandom_range(0, 7));
                dec_rs2[k*RW +: RW] = RW'($urandom_range(0, 7));
                dec_new_tag[k*TW +: TW] = TW'($urandom_range(0, 7));
            end
            if_rs_jalr = RW'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < IW; k++) begin
                model_read(k, dec_rs1[k*RW +: RW], ev, et);
                vectors++;
                if (value1_out[k*XL +: XL] !== ev || dependency1_out[k*TW +: TW] !== et) begin
                    errors++;
                    $display("FAIL rand_op1 n=%0d slot=%0d: got %h/%0d want %h/%0d", n, k,
                             value1_out[k*XL +: XL], dependency1_out[k*TW +: TW], ev, et);
                end
                model_read(k, dec_rs2[k*RW +: RW], ev, et);
                vectors++;
                if (value2_out[k*XL +: XL] !== ev || dependency2_out[k*TW +: TW] !== et) begin
                    errors++;
                    $display("FAIL rand_op2 n=%0d slot=%0d: got %h/%0d want %h/%0d", n, k,
                             value2_out[k*XL +: XL], dependency2_out[k*TW +: TW], ev, et);
                end
            end
            ev = (if_rs_jalr == 0) ? '0 : m_regs[if_rs_jalr];
            vectors++;
            if (value_jalr_out !== ev || jalr_busy_out !== (m_tags[if_rs_jalr] != NONE)) begin
                errors++;
                $display("FAIL rand_jalr n=%0d: got %h/%b want %h/%b", n, value_jalr_out, jalr_busy_out,
                         ev, (m_tags[if_rs_jalr] != NONE));
            end
            @(posedge clk_in);
            if (rdy_in) model_update();
            @(negedge clk_in);
        end
    endtask

    initial begin
        clear_inputs();
        rst_in = 1'b1;
        #12;
        rst_in = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_intra_group();
        test_commit_forward();
        test_stale_commit();
        test_collisions();
        test_flush_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
